regfile_reader: RTL and testbench

Sequential read-out engine for the register file: on a start pulse it walks a latched address range, reads one register per step through the register file's combinational read port, and presents each `{address, value}` pair on a valid/ready output stream. It is the read-side counterpart of the enable-gated register write path. It sits between the register file and any consumer that needs a register dump, such as a debug/trace port or a context-save unit.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_reader_if.sv | 28 ++
 rtl/regfile_reader_wrap_counter.sv | 32 +++
 rtl/regfile_reader.sv | 103 ++++++++++
 tb/tb_regfile_reader.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Types and default sizes shared by the register file and its read-out engine.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } rr_state_t;

  localparam int REG_COUNT  = 32;
  localparam int REG_WIDTH  = 32;
  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/regfile_reader_if.sv
// Control, register-file read port and output stream of the read-out engine.
interface regfile_reader_if #(
  parameter int ADDR_W = 5,
  parameter int WIDTH  = 32
);
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [WIDTH-1:0]  out_data;
  logic              busy;
  logic              done;

  // master: the reader itself; slave: register file plus consumer side
  modport master (
    input  start, first_addr, last_addr, rd_data, out_ready,
    output rd_addr, out_valid, out_addr, out_data, busy, done
  );

  modport slave (
    output start, first_addr, last_addr, rd_data, out_ready,
    input  rd_addr, out_valid, out_addr, out_data, busy, done
  );
endinterface

// File: rtl/regfile_reader_wrap_counter.sv
// Loadable address walker: holds the current index and the latched end bound.
module wrap_counter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W-1:0] bound,
  input  logic              inc,
  output logic [ADDR_W-1:0] idx,
  output logic              at_last
);

  logic [ADDR_W-1:0] last;

  // Register count is a power of two, so natural overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      last <= '0;
    end else if (load) begin
      idx  <= first;
      last <= bound;
    end else if (inc) begin
      idx  <= idx + ADDR_W'(1);
    end
  end

  assign at_last = (idx == last);

endmodule

// File: rtl/regfile_reader.sv
// Walks a latched address range and streams {address, value} pairs out of the
// register file's combinational read port over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; range latched when start is seen
// FETCH | rd_addr = idx; word captured at the end of this cycle
// HOLD  | word presented, waiting for out_ready
module regfile_reader
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = REG_COUNT,
  parameter int WIDTH    = REG_WIDTH,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  regfile_reader_if.master bus
);

  rr_state_t state, state_nxt;

  logic              load;
  logic              inc;
  logic              at_last;
  logic              hs;
  logic [ADDR_W-1:0] idx;
  logic              out_valid_q;
  logic              done_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [WIDTH-1:0]  out_data_q;

  wrap_counter #(.ADDR_W(ADDR_W)) u_wrap_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .first   (bus.first_addr),
    .bound   (bus.last_addr),
    .inc     (inc),
    .idx     (idx),
    .at_last (at_last)
  );

  assign hs = out_valid_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    inc       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = HOLD;
      HOLD: begin
        if (hs) begin
          if (at_last) begin
            state_nxt = IDLE;
          end else begin
            inc       = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The word is sampled at the edge ending FETCH, so a write landing in that
  // same cycle is what the consumer sees.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      done_q <= (state == HOLD) && hs && at_last;
      if (state == FETCH) begin
        out_valid_q <= 1'b1;
        out_addr_q  <= idx;
        out_data_q  <= bus.rd_data;
      end else if (hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rd_addr   = idx;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader with a behavioural 32x32 register file.
module tb_regfile_reader;

  logic clk = 1'b0;
  logic reset;

  regfile_reader_if #(.ADDR_W(5), .WIDTH(32)) bus ();

  regfile_reader #(.NUM_REGS(32), .WIDTH(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [32];
  assign bus.rd_data = regs[bus.rd_addr];

  int vectors    = 0;
  int miscompares = 0;

  int got_addr [$];
  int got_data [$];
  int done_cnt;
  int done_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int first, input int last);
    bus.first_addr = 5'(first);
    bus.last_addr  = 5'(last);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // Records every presented word (ready assumed high) until done or budget.
  task automatic collect(input int max_cyc);
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 0; c <= max_cyc; c++) begin
      if (bus.out_valid) begin
        got_addr.push_back(int'(bus.out_addr));
        got_data.push_back(int'(bus.out_data));
      end
      if (bus.done) begin
        done_cnt = 1;
        done_cyc = c;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int exp_wrap [4];
    exp_wrap = '{30, 31, 0, 1};

    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_valid", bus.out_valid, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_done",  bus.done, 0);
    check("rst_addr",  bus.out_addr, 0);
    check("rst_data",  bus.out_data, 0);
    check("rst_rdaddr", bus.rd_addr, 0);

    // Full dump 0..31
    bus.out_ready = 1'b1;
    pulse_start(0, 31);
    check("full_busy", bus.busy, 1);
    collect(80);
    check("full_count", got_addr.size(), 32);
    for (int i = 0; i < got_addr.size() && i < 32; i++) begin
      check("full_addr", got_addr[i], i);
      check("full_data", got_data[i], i * 3);
    end
    check("full_done_seen", done_cnt, 1);
    check("full_done_cyc", done_cyc, 64);
    check("full_busy_drop", bus.busy, 0);
    tick();
    check("full_done_pulse", bus.done, 0);

    // Backpressure on a single word
    regs[5] = 32'd88;
    bus.out_ready = 1'b0;
    pulse_start(5, 5);
    check("bp_fetch_valid", bus.out_valid, 0);
    check("bp_rdaddr", bus.rd_addr, 5);
    tick();
    check("bp_addr", bus.out_addr, 5);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid_held", bus.out_valid, 1);
      check("bp_data_stable", bus.out_data, 88);
      check("bp_no_done", bus.done, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_valid_clr", bus.out_valid, 0);
    check("bp_done", bus.done, 1);
    check("bp_busy", bus.busy, 0);
    tick();

    // Wrapping range 30..1
    pulse_start(30, 1);
    collect(20);
    check("wrap_count", got_addr.size(), 4);
    for (int i = 0; i < got_addr.size() && i < 4; i++) begin
      check("wrap_addr", got_addr[i], exp_wrap[i]);
      check("wrap_data", got_data[i], exp_wrap[i] * 3);
    end
    check("wrap_done", done_cnt, 1);
    tick();

    // Second start while busy must be ignored
    pulse_start(2, 4);
    bus.first_addr = 5'd10;
    bus.last_addr  = 5'd12;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    collect(20);
    check("busy_count", got_addr.size(), 3);
    for (int i = 0; i < got_addr.size() && i < 3; i++)
      check("busy_addr", got_addr[i], i + 2);
    check("busy_done", done_cnt, 1);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done || bus.busy) done_cnt++;
    end
    check("busy_no_restart", done_cnt, 0);

    // Reset while holding word 3 of 0..7
    pulse_start(0, 7);
    for (int c = 0; c < 30; c++) begin
      if (bus.out_valid && bus.out_addr == 5'd3) break;
      tick();
    end
    check("rstmid_reached", bus.out_addr, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_valid", bus.out_valid, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_done", bus.done, 0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done || bus.out_valid) done_cnt++;
    end
    check("rstmid_quiet", done_cnt, 0);
    pulse_start(7, 7);
    tick();
    check("rstmid_valid7", bus.out_valid, 1);
    check("rstmid_addr7", bus.out_addr, 7);
    check("rstmid_data7", bus.out_data, 21);
    tick();
    check("rstmid_done7", bus.done, 1);
    tick();

    // Write landing in the FETCH cycle of idx 4
    bus.out_ready = 1'b0;
    pulse_start(4, 4);
    regs[4] = 32'd89;
    tick();
    check("cw_valid", bus.out_valid, 1);
    check("cw_data", bus.out_data, 89);
    bus.out_ready = 1'b1;
    tick();
    check("cw_done", bus.done, 1);

    // start accepted in the done cycle
    pulse_start(1, 1);
    check("bb_busy", bus.busy, 1);
    collect(10);
    check("bb_count", got_addr.size(), 1);
    check("bb_done", done_cnt, 1);
    if (got_data.size() > 0) check("bb_data", got_data[0], 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
